// File: rtl/poro_pkg.sv
// poro_pkg: shared types and constants for the poro lane tracker.
//   lane_state_e : per-lane state (IDLE / WALK / PULLED)
//   DEF_*        : default geometry, speed and spawn-timing constants
//   popcount8    : number of set bits in an 8-bit vector (lane count <= 8)
package poro_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_WALK   = 2'd1,
    LANE_PULLED = 2'd2
  } lane_state_e;

  localparam int MAX_LANES     = 8;
  localparam int DEF_X_W       = 9;
  localparam int DEF_X_SPAWN   = 319;
  localparam int DEF_X_LIMIT   = 43;
  localparam int DEF_WALK_V    = 1;
  localparam int DEF_GRAB_V    = 4;
  localparam int DEF_SPAWN_GAP = 64;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/poro_lane.sv
// poro_lane: one poro lane -- state register, x register, crossing detect.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   clear_i          : force lane to IDLE at X_SPAWN (hold / game over)
//   frame_i          : frame tick, moves a WALK/PULLED lane
//   spawn_i          : this lane is chosen to spawn (only acts when IDLE)
//   grab_i           : an accepted grab targets this lane
//   x_o              : current x position
//   state_o          : current lane state (debug / status)
//   cross_walk_o     : combinational, lane crosses the kill line while walking
//   cross_pulled_o   : combinational, lane crosses the kill line while pulled
//   grab_hit_o       : combinational, the grab takes effect this cycle
module poro_lane import poro_pkg::*; #(
  parameter int X_W     = DEF_X_W,
  parameter int X_SPAWN = DEF_X_SPAWN,
  parameter int X_LIMIT = DEF_X_LIMIT,
  parameter int WALK_V  = DEF_WALK_V,
  parameter int GRAB_V  = DEF_GRAB_V
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_i,
  input  logic           frame_i,
  input  logic           spawn_i,
  input  logic           grab_i,
  output logic [X_W-1:0] x_o,
  output lane_state_e    state_o,
  output logic           cross_walk_o,
  output logic           cross_pulled_o,
  output logic           grab_hit_o
);

  localparam logic [X_W-1:0] SPAWN_X  = X_W'(X_SPAWN);
  localparam logic [X_W-1:0] V_WALK   = X_W'(WALK_V);
  localparam logic [X_W-1:0] V_GRAB   = X_W'(GRAB_V);
  // One extra bit so X_LIMIT + v can never wrap.
  localparam logic [X_W:0]   LIM_WALK = (X_W+1)'(X_LIMIT + WALK_V);
  localparam logic [X_W:0]   LIM_GRAB = (X_W+1)'(X_LIMIT + GRAB_V);

  lane_state_e    state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] vel;
  logic [X_W:0]   lim;
  logic           moving;
  logic           crossing;

  always_comb begin
    vel      = (state_q == LANE_PULLED) ? V_GRAB : V_WALK;
    lim      = (state_q == LANE_PULLED) ? LIM_GRAB : LIM_WALK;
    moving   = frame_i && (state_q != LANE_IDLE);
    // Compare against limit + v before subtracting: no underflow possible.
    crossing = moving && ({1'b0, x_q} < lim);

    state_d        = state_q;
    x_d            = x_q;
    cross_walk_o   = 1'b0;
    cross_pulled_o = 1'b0;
    grab_hit_o     = 1'b0;

    if (clear_i) begin
      state_d = LANE_IDLE;
      x_d     = SPAWN_X;
    end else begin
      if (crossing) begin
        state_d        = LANE_IDLE;
        x_d            = SPAWN_X;
        cross_walk_o   = (state_q == LANE_WALK);
        cross_pulled_o = (state_q == LANE_PULLED);
      end else if (moving) begin
        x_d = x_q - vel;
      end
      // An IDLE lane never moves, so a spawn frame leaves x at X_SPAWN.
      if ((state_q == LANE_IDLE) && spawn_i) begin
        state_d = LANE_WALK;
        x_d     = SPAWN_X;
      end
      // A grab only lands on a lane still walking after this frame's update;
      // a crossing on the same frame wins.
      if ((state_q == LANE_WALK) && !crossing && grab_i) begin
        state_d    = LANE_PULLED;
        grab_hit_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE_IDLE;
      x_q     <= SPAWN_X;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

  assign x_o     = x_q;
  assign state_o = state_q;

endmodule

// File: rtl/poro_lane_array.sv
// poro_lane_array: NUM_PORO independent poro lanes plus spawn timing,
// grab decode and score/lives HUD accounting.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   frame        : one-cycle pulse per video frame
//   hold         : level, parks every lane at X_SPAWN and clears spawn timer
//   grab_valid   : grab request, grab_idx selects the lane
//   grab_ready   : combinational, grabs accepted (!hold && !game_over)
//   grab_hit     : registered pulse, an accepted grab hit a walking lane
//   x_out        : lane i x at [i*X_W +: X_W]
//   active       : lane is WALK or PULLED
//   pulled       : lane is PULLED
//   score        : saturating catch count
//   lives        : remaining lives, saturating at 0
//   score_pulse  : one-cycle pulse after a frame with any catch
//   miss_pulse   : one-cycle pulse after a frame with any miss
//   game_over    : latched when lives reach 0, cleared only by reset
//
// Grab handshake: a grab is taken on any cycle where grab_valid && grab_ready;
// there is no back-pressure beyond grab_ready, and an accepted grab whose
// target lane is not walking (or out of range) is silently dropped.
module poro_lane_array import poro_pkg::*; #(
  parameter int  NUM_PORO  = 4,
  parameter int  X_W       = DEF_X_W,
  parameter int  X_SPAWN   = DEF_X_SPAWN,
  parameter int  X_LIMIT   = DEF_X_LIMIT,
  parameter int  WALK_V    = DEF_WALK_V,
  parameter int  GRAB_V    = DEF_GRAB_V,
  parameter int  SPAWN_GAP = DEF_SPAWN_GAP,
  parameter int  SCORE_W   = 8,
  parameter int  LIVES     = 3,
  localparam int LIVES_W   = $clog2(LIVES + 1),
  localparam int IDX_W     = (NUM_PORO > 1) ? $clog2(NUM_PORO) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame,
  input  logic                    hold,
  input  logic                    grab_valid,
  input  logic [IDX_W-1:0]        grab_idx,
  output logic                    grab_ready,
  output logic                    grab_hit,
  output logic [NUM_PORO*X_W-1:0] x_out,
  output logic [NUM_PORO-1:0]     active,
  output logic [NUM_PORO-1:0]     pulled,
  output logic [SCORE_W-1:0]      score,
  output logic [LIVES_W-1:0]      lives,
  output logic                    score_pulse,
  output logic                    miss_pulse,
  output logic                    game_over
);

  localparam int CNT_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int SSUM_W = SCORE_W + 4;
  localparam int LSUM_W = LIVES_W + 4;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SPAWN_GAP - 1);
  localparam logic [SSUM_W-1:0] SCORE_MAX = SSUM_W'({SCORE_W{1'b1}});

  logic [CNT_W-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic                spawn_fire;
  logic                clear_lanes;
  logic                grab_accept;
  logic [NUM_PORO-1:0] idle_vec, spawn_vec, grab_vec;
  logic [NUM_PORO-1:0] cross_walk, cross_pulled, lane_hit;
  lane_state_e         lane_state [NUM_PORO];

  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                game_over_q, game_over_d;
  logic                grab_hit_q, score_pulse_q, miss_pulse_q;
  logic [3:0]          n_catch, n_miss;
  logic [SSUM_W-1:0]   score_sum;

  assign clear_lanes = hold | game_over_q;
  assign grab_ready  = !hold && !game_over_q;
  assign grab_accept = grab_valid && grab_ready;

  // Spawn timer: wraps on every SPAWN_GAP-th frame whether or not a lane
  // was free to take the spawn.
  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    spawn_fire  = 1'b0;
    if (clear_lanes) begin
      spawn_cnt_d = '0;
    end else if (frame) begin
      if (spawn_cnt_q == CNT_LAST) begin
        spawn_cnt_d = '0;
        spawn_fire  = 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q + 1'b1;
      end
    end
  end

  // Lowest set bit of the idle vector picks the spawning lane.
  assign spawn_vec = spawn_fire ? (idle_vec & (~idle_vec + NUM_PORO'(1))) : '0;

  for (genvar i = 0; i < NUM_PORO; i++) begin : g_lane
    // Out-of-range indices match no lane and are dropped here.
    assign grab_vec[i] = grab_accept && (grab_idx == IDX_W'(i));

    poro_lane #(
      .X_W     (X_W),
      .X_SPAWN (X_SPAWN),
      .X_LIMIT (X_LIMIT),
      .WALK_V  (WALK_V),
      .GRAB_V  (GRAB_V)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .clear_i        (clear_lanes),
      .frame_i        (frame),
      .spawn_i        (spawn_vec[i]),
      .grab_i         (grab_vec[i]),
      .x_o            (x_out[i*X_W +: X_W]),
      .state_o        (lane_state[i]),
      .cross_walk_o   (cross_walk[i]),
      .cross_pulled_o (cross_pulled[i]),
      .grab_hit_o     (lane_hit[i])
    );

    assign idle_vec[i] = (lane_state[i] == LANE_IDLE);
    assign active[i]   = (lane_state[i] != LANE_IDLE);
    assign pulled[i]   = (lane_state[i] == LANE_PULLED);
  end

  always_comb begin
    n_catch   = popcount8(8'(cross_pulled));
    n_miss    = popcount8(8'(cross_walk));
    score_sum = SSUM_W'(score_q) + SSUM_W'(n_catch);
    score_d   = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
    if (LSUM_W'(n_miss) >= LSUM_W'(lives_q)) begin
      lives_d = '0;
    end else begin
      lives_d = lives_q - LIVES_W'(n_miss);
    end
    game_over_d = game_over_q | (lives_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spawn_cnt_q   <= '0;
      score_q       <= '0;
      lives_q       <= LIVES_W'(LIVES);
      game_over_q   <= 1'b0;
      grab_hit_q    <= 1'b0;
      score_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
    end else begin
      spawn_cnt_q   <= spawn_cnt_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      grab_hit_q    <= |lane_hit;
      score_pulse_q <= |cross_pulled;
      miss_pulse_q  <= |cross_walk;
    end
  end

  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign grab_hit    = grab_hit_q;
  assign score_pulse = score_pulse_q;
  assign miss_pulse  = miss_pulse_q;

endmodule

// File: tb/tb_poro_lane_array.sv
// Directed bench for poro_lane_array with NUM_PORO=3, SPAWN_GAP=4, SCORE_W=2.
module tb_poro_lane_array;

  localparam int NP = 3;
  localparam int XW = 9;
  localparam int SW = 2;
  localparam int LW = 2;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           frame = 1'b0;
  logic           hold = 1'b0;
  logic           grab_valid = 1'b0;
  logic [IW-1:0]  grab_idx = '0;
  logic           grab_ready, grab_hit, score_pulse, miss_pulse, game_over;
  logic [NP*XW-1:0] x_out;
  logic [NP-1:0]  active, pulled;
  logic [SW-1:0]  score;
  logic [LW-1:0]  lives;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poro_lane_array #(
    .NUM_PORO  (NP),
    .SPAWN_GAP (4),
    .SCORE_W   (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame       (frame),
    .hold        (hold),
    .grab_valid  (grab_valid),
    .grab_idx    (grab_idx),
    .grab_ready  (grab_ready),
    .grab_hit    (grab_hit),
    .x_out       (x_out),
    .active      (active),
    .pulled      (pulled),
    .score       (score),
    .lives       (lives),
    .score_pulse (score_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  typedef struct {
    logic       f, h, gv;
    logic [1:0] gi;
    logic [2:0] act, pul;
    logic [8:0] x0, x1, x2;
    logic [1:0] sc, lv;
    logic       hit, rdy;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic f, input logic h, input logic gv,
                              input logic [1:0] gi, input logic [2:0] act,
                              input logic [2:0] pul, input int x0, input int x1,
                              input int x2, input logic hit, input logic rdy);
    vec_t v;
    v.f = f; v.h = h; v.gv = gv; v.gi = gi;
    v.act = act; v.pul = pul;
    v.x0 = 9'(x0); v.x1 = 9'(x1); v.x2 = 9'(x2);
    v.sc = 2'd0; v.lv = 2'd3;
    v.hit = hit; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] xl(input int i);
    return x_out[i*XW +: XW];
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic f, input logic h, input logic gv, input logic [1:0] gi);
    frame = f; hold = h; grab_valid = gv; grab_idx = gi;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic do_hold();
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    // Single-cycle vectors right after reset (spawn counter starts at 0).
    tbl[0]  = mk(0,0,0,0, 3'b000,3'b000, 319,319,319, 0,1);
    tbl[1]  = mk(1,0,0,0, 3'b000,3'b000, 319,319,319, 0,1);
    tbl[2]  = mk(1,0,0,0, 3'b000,3'b000, 319,319,319, 0,1);
    tbl[3]  = mk(1,0,0,0, 3'b000,3'b000, 319,319,319, 0,1);
    tbl[4]  = mk(1,0,0,0, 3'b001,3'b000, 319,319,319, 0,1); // 4th frame: lane 0 spawns
    tbl[5]  = mk(1,0,0,0, 3'b001,3'b000, 318,319,319, 0,1);
    tbl[6]  = mk(1,0,0,0, 3'b001,3'b000, 317,319,319, 0,1);
    tbl[7]  = mk(1,0,0,0, 3'b001,3'b000, 316,319,319, 0,1);
    tbl[8]  = mk(1,0,0,0, 3'b011,3'b000, 315,319,319, 0,1); // 8th frame: lane 1 spawns
    tbl[9]  = mk(0,0,1,0, 3'b011,3'b001, 315,319,319, 1,1); // grab walking lane 0
    tbl[10] = mk(0,0,0,0, 3'b011,3'b001, 315,319,319, 0,1);
    tbl[11] = mk(0,0,1,3, 3'b011,3'b001, 315,319,319, 0,1); // index out of range
    tbl[12] = mk(0,0,1,2, 3'b011,3'b001, 315,319,319, 0,1); // idle lane
    tbl[13] = mk(0,0,1,0, 3'b011,3'b001, 315,319,319, 0,1); // already pulled
    tbl[14] = mk(1,0,0,0, 3'b011,3'b001, 311,318,319, 0,1); // pulled moves 4, walk 1
    tbl[15] = mk(1,1,1,1, 3'b000,3'b000, 319,319,319, 0,0); // hold beats frame and grab
    tbl[16] = mk(1,0,0,0, 3'b000,3'b000, 319,319,319, 0,1); // counter was cleared

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NP; i++) check($sformatf("rst_x%0d", i), xl(i), 319);
    check("rst_active", active, 0);
    check("rst_pulled", pulled, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_grab_hit", grab_hit, 0);
    check("rst_score_pulse", score_pulse, 0);
    check("rst_miss_pulse", miss_pulse, 0);
    check("rst_game_over", game_over, 0);
    check("rst_grab_ready", grab_ready, 1);

    // Table-driven vectors.
    for (int r = 0; r < 17; r++) begin
      cyc(tbl[r].f, tbl[r].h, tbl[r].gv, tbl[r].gi);
      check($sformatf("v%0d_active", r), active, tbl[r].act);
      check($sformatf("v%0d_pulled", r), pulled, tbl[r].pul);
      check($sformatf("v%0d_x0", r), xl(0), tbl[r].x0);
      check($sformatf("v%0d_x1", r), xl(1), tbl[r].x1);
      check($sformatf("v%0d_x2", r), xl(2), tbl[r].x2);
      check($sformatf("v%0d_score", r), score, tbl[r].sc);
      check($sformatf("v%0d_lives", r), lives, tbl[r].lv);
      check($sformatf("v%0d_grab_hit", r), grab_hit, tbl[r].hit);
      check($sformatf("v%0d_grab_ready", r), grab_ready, tbl[r].rdy);
      check($sformatf("v%0d_score_pulse", r), score_pulse, 0);
      check($sformatf("v%0d_miss_pulse", r), miss_pulse, 0);
    end

    // Catch: pulled from 319 reaches 43 after 69 frames, scores on the 70th.
    do_hold();
    frames(4);
    check("catch_spawn_x0", xl(0), 319);
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    check("catch_grab_hit", grab_hit, 1);
    idle();
    check("catch_grab_hit_clr", grab_hit, 0);
    frames(69);
    check("catch_x0_at_limit", xl(0), 43);
    check("catch_no_pulse_yet", score_pulse, 0);
    frames(1);
    check("catch_score", score, 1);
    check("catch_score_pulse", score_pulse, 1);
    check("catch_lives", lives, 3);
    check("catch_x0_respawn", xl(0), 319);
    check("catch_lane0_idle", active[0], 0);
    idle();
    check("catch_score_pulse_clr", score_pulse, 0);

    // Simultaneous: lane 0 walking and lane 1 pulled cross on frame 281,
    // while a grab on lane 0 arrives on that same frame.
    do_hold();
    check("hold_score_kept", score, 1);
    check("hold_active", active, 0);
    frames(279);
    check("sim_x0", xl(0), 44);
    check("sim_x1", xl(1), 48);
    check("sim_x2", xl(2), 52);
    cyc(1'b0, 1'b0, 1'b1, 2'd1);
    check("sim_grab_hit", grab_hit, 1);
    check("sim_pulled", pulled, 3'b010);
    frames(1);
    check("sim_x1_pre", xl(1), 44);
    cyc(1'b1, 1'b0, 1'b1, 2'd0);
    check("sim_score", score, 2);
    check("sim_lives", lives, 2);
    check("sim_score_pulse", score_pulse, 1);
    check("sim_miss_pulse", miss_pulse, 1);
    check("sim_no_grab_hit", grab_hit, 0);
    check("sim_active", active, 3'b100);
    check("sim_pulled_after", pulled, 3'b000);
    check("sim_x2_after", xl(2), 50);
    idle();
    check("sim_pulses_clr", {score_pulse, miss_pulse}, 0);

    // Miss then game over: lane 0 misses on frame 281, lane 1 on frame 285.
    do_hold();
    frames(280);
    check("miss_x0_at_limit", xl(0), 43);
    frames(1);
    check("miss_pulse", miss_pulse, 1);
    check("miss_lives", lives, 1);
    check("miss_x0_respawn", xl(0), 319);
    check("miss_game_over_early", game_over, 0);
    frames(4);
    check("go_lives", lives, 0);
    check("go_flag", game_over, 1);
    check("go_miss_pulse", miss_pulse, 1);
    idle();
    check("go_grab_ready", grab_ready, 0);
    check("go_active", active, 0);
    frames(8);
    check("go_no_spawn", active, 0);
    check("go_lives_sat", lives, 0);
    check("go_score_kept", score, 2);
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    idle();
    check("go_grab_refused", grab_hit, 0);

    // Reset asserted between edges takes effect immediately.
    frame = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_game_over", game_over, 0);
    check("async_rst_lives", lives, 3);
    check("async_rst_score", score, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame = 1'b0;

    // Score saturation at 2 bits over five catches.
    for (int k = 1; k <= 5; k++) begin
      do_hold();
      frames(4);
      cyc(1'b0, 1'b0, 1'b1, 2'd0);
      frames(70);
      check($sformatf("sat%0d_score", k), score, (k > 3) ? 3 : k);
      check($sformatf("sat%0d_score_pulse", k), score_pulse, 1);
      check($sformatf("sat%0d_lives", k), lives, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/poro_lane_array.md
# poro_lane_array

Multi-lane poro tracker and the parametrised successor of the single-poro position block. It runs `NUM_PORO` independent poro lanes. Each lane walks left at walk speed and is pulled back at grab speed after a successful grab. A lane scores or costs a life when its poro crosses the kill line. The block sits between the hook/grab logic and the VGA sprite renderer, and also drives the score/lives HUD.

## Interface
Parameters:
- `NUM_PORO`, 4: number of lanes; 1..8.
- `X_W`, 9: x-coordinate width.
- `X_SPAWN`, 319: spawn/reset x.
- `X_LIMIT`, 43: kill-line x.
- `WALK_V`, 1: pixels per frame while walking.
- `GRAB_V`, 4: pixels per frame while pulled.
- `SPAWN_GAP`, 64: frames between spawn attempts.
- `SCORE_W`, 8: score counter width.
- `LIVES`, 3: starting lives; `LIVES_W` = `$clog2(LIVES+1)`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame` in 1: one-cycle pulse per video frame.
- `hold` in 1: level; parks all lanes.
- `grab_valid` in 1: grab request.
- `grab_idx` in `$clog2(NUM_PORO)` (min 1): target lane.
- `grab_ready` out 1: `!hold && !game_over` (combinational).
- `grab_hit` out 1: registered pulse; accepted grab hit a walking lane.
- `x_out` out `NUM_PORO*X_W`: lane i at bits `[i*X_W +: X_W]`.
- `active` out `NUM_PORO`: lane is WALK or PULLED.
- `pulled` out `NUM_PORO`: lane is PULLED.
- `score` out `SCORE_W`: saturating catch count.
- `lives` out `LIVES_W`: remaining lives.
- `score_pulse`, `miss_pulse` out 1: one-cycle pulse on the cycle after a scoring or missing crossing.
- `game_over` out 1: level; set when lives reach 0.

## Operation
- Each lane has three states:
  - IDLE: x = `X_SPAWN`, not moving.
  - WALK: v = `WALK_V`.
  - PULLED: v = `GRAB_V`.
- Movement happens on `frame` for every WALK/PULLED lane. Crossing test: `x < X_LIMIT + v` is evaluated before subtraction, so there is no underflow.
  - No crossing: x ← x − v.
  - Crossing: x ← `X_SPAWN` and the lane goes to IDLE.
  - A PULLED crossing is a catch: score +1, saturating at all-ones.
  - A WALK crossing is a miss: lives −1, saturating at 0.
- Spawn counter counts frames 0..`SPAWN_GAP`−1.
  - On the frame where it equals `SPAWN_GAP`−1, the lowest-index IDLE lane enters WALK at `X_SPAWN`, and the counter wraps to 0.
  - If no lane is IDLE, the spawn is skipped and the counter still wraps.
  - A lane does not move on its spawn frame.
- Grab: when `grab_valid && grab_ready`, a lane `grab_idx` in WALK goes to PULLED and `grab_hit` pulses.
  - Grab on an IDLE or PULLED lane: no effect and no `grab_hit`.
  - `grab_idx` ≥ `NUM_PORO`: ignored.
- Multiple lanes crossing on the same frame: score adds the count of PULLED crossings; lives subtract the count of WALK crossings, saturating at 0. Each pulse fires once regardless of count.
- `hold`: every cycle it is high, all lanes go to IDLE at `X_SPAWN` and the spawn counter clears. Score and lives are kept.
- `game_over`: latched when lives reach 0. All lanes go to IDLE, spawning stops, and grabs are refused. Only `reset` clears it.

## Timing
- Reset values:
  - `x_out` = `X_SPAWN` in every lane.
  - `active`, `pulled`, `score` = 0.
  - `lives` = `LIVES`.
  - `grab_hit`, `score_pulse`, `miss_pulse`, `game_over` = 0.
  - Spawn counter = 0.
- All outputs except `grab_ready` are registered. Effects of a `frame` or grab cycle are visible on the next cycle.
- Grab coincident with `frame`: the movement uses the pre-grab state. The grab applies only if the lane is still WALK after that update, i.e. it did not cross on that frame. Otherwise the crossing wins and counts as a miss.
- `hold` has priority over `frame`, spawn and grab. `game_over` takes effect on the cycle after lives reach 0.
- Asserting `reset` mid-frame returns all state to reset values immediately.

## Structure
- `poro_pkg` holds:
  - the lane-state enum (IDLE/WALK/PULLED);
  - default speed and coordinate constants;
  - the popcount function.
- Sub-module `poro_lane`: one lane's state register, x register, crossing detect and crossing-type outputs, generate-instanced `NUM_PORO` times.
- The top level owns the spawn counter, spawn arbiter, grab decode, score/lives accumulation and pulses.

## Test plan
- Spawn: `NUM_PORO`=2, `SPAWN_GAP`=4, reset then 4 frames → lane 0 active at x=319. Next frame → x=318. After 8 frames, lane 1 is also active.
- Miss: lane 0 walking from 319 → x=43 after 276 moving frames. The 277th frame gives `miss_pulse`, lives 3→2, lane 0 idle at 319.
- Catch: grab lane 0 at x=319 → `grab_hit`. After 69 frames x=43; the 70th frame gives `score_pulse`, score=1.
- Simultaneous events: two lanes cross on the same frame, one PULLED and one WALK → score +1, lives −1, both pulses fire once. Grab on the crossing frame → still a miss, no `grab_hit`.
- Hold and game over: `hold` mid-walk → all x=319, `active`=0, score kept. Three misses → `game_over`=1, `grab_ready`=0, no further spawns until `reset`.
- Saturation and bad index: `SCORE_W`=2 with 5 catches → score=3. `grab_idx`=3 with `NUM_PORO`=3 → ignored, no `grab_hit`.
